npu_fifo_endpoint: RTL and testbench

NPU-side endpoint for the CPU-to-NPU queue interface driven by the execution stage. It accepts configuration words and enqueued operands written by the CPU, buffers them, and streams them to the NPU core over valid/ready. It also collects NPU results into an output queue, which the CPU dequeues with a registered one-cycle read. Occupancy flags feed the CPU hazard unit so that it stalls before overflow or underflow.

---
 rtl/npu_fifo_endpoint_pkg.sv | 18 +
 rtl/npu_sync_fifo.sv | 87 ++++++++
 rtl/npu_fifo_endpoint.sv | 148 ++++++++++++++
 tb/tb_npu_fifo_endpoint.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_fifo_endpoint_pkg.sv
// -----------------------------------------------------------------------------
// npu_fifo_endpoint_pkg
// Shared constants for the CPU<->NPU queue endpoint: word width, default FIFO
// depths and the occupancy-counter width helper used by every FIFO instance.
// -----------------------------------------------------------------------------
package npu_fifo_endpoint_pkg;

   localparam int unsigned NPU_WORD_W        = 32;
   localparam int unsigned NPU_CFG_DEPTH_DEF = 16;
   localparam int unsigned NPU_IN_DEPTH_DEF  = 32;
   localparam int unsigned NPU_OUT_DEPTH_DEF = 32;

   // Count must reach DEPTH itself, hence one bit more than the pointer.
   function automatic int unsigned fifoCntWidth(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// -----------------------------------------------------------------------------
// npu_sync_fifo
// Single-clock FIFO with registered occupancy count and a combinational head.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   iFlush       : synchronous clear of pointers and count; discards same-cycle ops
//   iPush, iData : write request and data
//   iPop         : read request (ignored while empty)
//   oHead        : word at the read pointer (combinational storage read)
//   oFull/oEmpty : decoded from the registered count only
// A push while full is accepted only if a pop happens in the same cycle.
// A push while empty is never forwarded to oHead in the same cycle.
// -----------------------------------------------------------------------------
module npu_sync_fifo
   import npu_fifo_endpoint_pkg::*;
#(
   parameter int unsigned WIDTH = NPU_WORD_W,
   parameter int unsigned DEPTH = NPU_CFG_DEPTH_DEF
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iFlush,
   input  logic             iPush,
   input  logic [WIDTH-1:0] iData,
   input  logic             iPop,
   output logic [WIDTH-1:0] oHead,
   output logic             oFull,
   output logic             oEmpty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = fifoCntWidth(DEPTH);

   logic [PtrW-1:0]  wrPtrQ, wrPtrD;
   logic [PtrW-1:0]  rdPtrQ, rdPtrD;
   logic [CntW-1:0]  countQ, countD;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             pushEff, popEff;

   assign oFull  = (countQ == CntW'(DEPTH));
   assign oEmpty = (countQ == '0);

   assign popEff  = iPop && !oEmpty;
   // When full, a simultaneous pop frees the slot the push needs.
   assign pushEff = iPush && (!oFull || popEff);

   always_comb begin
      wrPtrD = wrPtrQ;
      rdPtrD = rdPtrQ;
      countD = countQ;
      if (iFlush) begin
         wrPtrD = '0;
         rdPtrD = '0;
         countD = '0;
      end else begin
         // DEPTH is a power of two, so pointer wrap is natural overflow.
         if (pushEff) wrPtrD = wrPtrQ + PtrW'(1);
         if (popEff)  rdPtrD = rdPtrQ + PtrW'(1);
         if (pushEff && !popEff) begin
            countD = countQ + CntW'(1);
         end else if (!pushEff && popEff) begin
            countD = countQ - CntW'(1);
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         wrPtrQ <= wrPtrD;
         rdPtrQ <= rdPtrD;
         countQ <= countD;
      end
   end

   // Storage is not reset; the count alone decides what is valid.
   always_ff @(posedge iClk) begin
      if (pushEff && !iFlush) begin
         mem[wrPtrQ] <= iData;
      end
   end

   assign oHead = mem[rdPtrQ];

endmodule

// File: rtl/npu_fifo_endpoint.sv
// -----------------------------------------------------------------------------
// npu_fifo_endpoint
// NPU-side endpoint of the CPU<->NPU queue interface.
//   CPU side : iNpuConfigFifo/We and iNpuDataFifo/We push config words and
//              operands; iNpuDataRe dequeues a result into the registered
//              oNpuDataFifo (valid the cycle after the request).
//              oCfgFull, oInFull, oOutEmpty feed the hazard unit;
//              oOverflow/oUnderflow are sticky error flags.
//   Core side: oCoreCfg*/iCoreCfgReady and oCoreIn*/iCoreInReady stream config
//              and operands; iCoreOut*/oCoreOutReady collect results.
//   iNpuFlush: synchronous clear of all FIFOs and both error flags.
// -----------------------------------------------------------------------------
module npu_fifo_endpoint
   import npu_fifo_endpoint_pkg::*;
#(
   parameter int unsigned CFG_DEPTH = NPU_CFG_DEPTH_DEF,
   parameter int unsigned IN_DEPTH  = NPU_IN_DEPTH_DEF,
   parameter int unsigned OUT_DEPTH = NPU_OUT_DEPTH_DEF
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic [NPU_WORD_W-1:0] iNpuConfigFifo,
   input  logic                  iNpuConfigWe,
   input  logic [NPU_WORD_W-1:0] iNpuDataFifo,
   input  logic                  iNpuDataWe,
   input  logic                  iNpuDataRe,
   input  logic                  iNpuFlush,
   output logic [NPU_WORD_W-1:0] oNpuDataFifo,
   output logic                  oCfgFull,
   output logic                  oInFull,
   output logic                  oOutEmpty,
   output logic                  oOverflow,
   output logic                  oUnderflow,
   output logic [NPU_WORD_W-1:0] oCoreCfgData,
   output logic                  oCoreCfgValid,
   input  logic                  iCoreCfgReady,
   output logic [NPU_WORD_W-1:0] oCoreInData,
   output logic                  oCoreInValid,
   input  logic                  iCoreInReady,
   input  logic [NPU_WORD_W-1:0] iCoreOutData,
   input  logic                  iCoreOutValid,
   output logic                  oCoreOutReady
);

   logic                  cfgEmpty, inEmpty, outFull;
   logic                  cfgPop, inPop, outPush, outPop;
   logic                  cfgDrop, inDrop;
   logic [NPU_WORD_W-1:0] outHead;
   logic                  overflowQ, overflowD;
   logic                  underflowQ, underflowD;
   logic [NPU_WORD_W-1:0] rdDataQ, rdDataD;

   assign oCoreCfgValid = !cfgEmpty;
   assign oCoreInValid  = !inEmpty;
   assign oCoreOutReady = !outFull;

   assign cfgPop  = oCoreCfgValid && iCoreCfgReady;
   assign inPop   = oCoreInValid && iCoreInReady;
   assign outPush = iCoreOutValid && oCoreOutReady;
   assign outPop  = iNpuDataRe && !oOutEmpty;

   // A CPU write is lost only when full and nothing leaves in the same cycle.
   assign cfgDrop = iNpuConfigWe && oCfgFull && !cfgPop;
   assign inDrop  = iNpuDataWe && oInFull && !inPop;

   npu_sync_fifo #(
      .WIDTH (NPU_WORD_W),
      .DEPTH (CFG_DEPTH)
   ) uCfgFifo (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iFlush (iNpuFlush),
      .iPush  (iNpuConfigWe),
      .iData  (iNpuConfigFifo),
      .iPop   (cfgPop),
      .oHead  (oCoreCfgData),
      .oFull  (oCfgFull),
      .oEmpty (cfgEmpty)
   );

   npu_sync_fifo #(
      .WIDTH (NPU_WORD_W),
      .DEPTH (IN_DEPTH)
   ) uInFifo (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iFlush (iNpuFlush),
      .iPush  (iNpuDataWe),
      .iData  (iNpuDataFifo),
      .iPop   (inPop),
      .oHead  (oCoreInData),
      .oFull  (oInFull),
      .oEmpty (inEmpty)
   );

   npu_sync_fifo #(
      .WIDTH (NPU_WORD_W),
      .DEPTH (OUT_DEPTH)
   ) uOutFifo (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iFlush (iNpuFlush),
      .iPush  (outPush),
      .iData  (iCoreOutData),
      .iPop   (outPop),
      .oHead  (outHead),
      .oFull  (outFull),
      .oEmpty (oOutEmpty)
   );

   always_comb begin
      overflowD  = overflowQ;
      underflowD = underflowQ;
      rdDataD    = rdDataQ;
      if (iNpuFlush) begin
         // Flush discards the same-cycle pop, so the read register holds.
         overflowD  = 1'b0;
         underflowD = 1'b0;
      end else begin
         if (cfgDrop || inDrop) overflowD = 1'b1;
         if (iNpuDataRe) begin
            if (oOutEmpty) begin
               rdDataD    = '0;
               underflowD = 1'b1;
            end else begin
               rdDataD = outHead;
            end
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         overflowQ  <= 1'b0;
         underflowQ <= 1'b0;
         rdDataQ    <= '0;
      end else begin
         overflowQ  <= overflowD;
         underflowQ <= underflowD;
         rdDataQ    <= rdDataD;
      end
   end

   assign oOverflow    = overflowQ;
   assign oUnderflow   = underflowQ;
   assign oNpuDataFifo = rdDataQ;

endmodule

// File: tb/tb_npu_fifo_endpoint.sv
module tb_npu_fifo_endpoint;

   localparam int unsigned CFG_DEPTH = 16;
   localparam int unsigned IN_DEPTH  = 32;
   localparam int unsigned OUT_DEPTH = 32;

   logic        iClk;
   logic        iRst_n;
   logic [31:0] iNpuConfigFifo;
   logic        iNpuConfigWe;
   logic [31:0] iNpuDataFifo;
   logic        iNpuDataWe;
   logic        iNpuDataRe;
   logic        iNpuFlush;
   logic [31:0] oNpuDataFifo;
   logic        oCfgFull, oInFull, oOutEmpty, oOverflow, oUnderflow;
   logic [31:0] oCoreCfgData;
   logic        oCoreCfgValid;
   logic        iCoreCfgReady;
   logic [31:0] oCoreInData;
   logic        oCoreInValid;
   logic        iCoreInReady;
   logic [31:0] iCoreOutData;
   logic        iCoreOutValid;
   logic        oCoreOutReady;

   int checks = 0;
   int errors = 0;

   // Reference model: plain queues plus the visible registers.
   logic [31:0] mCfg[$];
   logic [31:0] mIn[$];
   logic [31:0] mOut[$];
   bit          mOvf, mUnf;
   logic [31:0] mData;

   npu_fifo_endpoint #(
      .CFG_DEPTH (CFG_DEPTH),
      .IN_DEPTH  (IN_DEPTH),
      .OUT_DEPTH (OUT_DEPTH)
   ) dut (
      .iClk           (iClk),
      .iRst_n         (iRst_n),
      .iNpuConfigFifo (iNpuConfigFifo),
      .iNpuConfigWe   (iNpuConfigWe),
      .iNpuDataFifo   (iNpuDataFifo),
      .iNpuDataWe     (iNpuDataWe),
      .iNpuDataRe     (iNpuDataRe),
      .iNpuFlush      (iNpuFlush),
      .oNpuDataFifo   (oNpuDataFifo),
      .oCfgFull       (oCfgFull),
      .oInFull        (oInFull),
      .oOutEmpty      (oOutEmpty),
      .oOverflow      (oOverflow),
      .oUnderflow     (oUnderflow),
      .oCoreCfgData   (oCoreCfgData),
      .oCoreCfgValid  (oCoreCfgValid),
      .iCoreCfgReady  (iCoreCfgReady),
      .oCoreInData    (oCoreInData),
      .oCoreInValid   (oCoreInValid),
      .iCoreInReady   (iCoreInReady),
      .iCoreOutData   (iCoreOutData),
      .iCoreOutValid  (iCoreOutValid),
      .oCoreOutReady  (oCoreOutReady)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic modelClear();
      mCfg.delete();
      mIn.delete();
      mOut.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
   endtask

   // Applies the rules of one clock edge to the model, using the inputs held
   // across that edge.
   task automatic modelStep();
      bit cPop, dPop, cAcc, dAcc, oPush;
      if (iNpuFlush) begin
         modelClear();
         return;
      end
      cPop = iCoreCfgReady && (mCfg.size() != 0);
      dPop = iCoreInReady && (mIn.size() != 0);
      cAcc = iNpuConfigWe && (mCfg.size() < CFG_DEPTH || cPop);
      dAcc = iNpuDataWe && (mIn.size() < IN_DEPTH || dPop);
      if ((iNpuConfigWe && !cAcc) || (iNpuDataWe && !dAcc)) mOvf = 1'b1;
      if (cPop) void'(mCfg.pop_front());
      if (dPop) void'(mIn.pop_front());
      if (cAcc) mCfg.push_back(iNpuConfigFifo);
      if (dAcc) mIn.push_back(iNpuDataFifo);
      oPush = iCoreOutValid && (mOut.size() < OUT_DEPTH);
      if (iNpuDataRe) begin
         if (mOut.size() != 0) begin
            mData = mOut.pop_front();
         end else begin
            mData = 32'h0;
            mUnf  = 1'b1;
         end
      end
      if (oPush) mOut.push_back(iCoreOutData);
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
      modelStep();
   endtask

   task automatic idleInputs();
      iNpuConfigFifo = '0;
      iNpuConfigWe   = 1'b0;
      iNpuDataFifo   = '0;
      iNpuDataWe     = 1'b0;
      iNpuDataRe     = 1'b0;
      iNpuFlush      = 1'b0;
      iCoreCfgReady  = 1'b0;
      iCoreInReady   = 1'b0;
      iCoreOutData   = '0;
      iCoreOutValid  = 1'b0;
   endtask

   task automatic flush();
      iNpuFlush = 1'b1;
      tick();
      iNpuFlush = 1'b0;
   endtask

   task automatic test_reset();
      idleInputs();
      iRst_n = 1'b0;
      modelClear();
      mData = 32'h0;
      repeat (2) @(posedge iClk);
      #1;
      iRst_n = 1'b1;
      tick();
      checks++;
      if ({oCoreCfgValid, oCoreInValid, oCfgFull, oInFull, oOverflow, oUnderflow} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000000",
                  {oCoreCfgValid, oCoreInValid, oCfgFull, oInFull, oOverflow, oUnderflow});
      end
      checks++;
      if (oOutEmpty !== 1'b1 || oCoreOutReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_out: got empty=%b ready=%b required 1 1", oOutEmpty, oCoreOutReady);
      end
      checks++;
      if (oNpuDataFifo !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got %h required 0", oNpuDataFifo);
      end
   endtask

   task automatic test_cfg_stream();
      logic [31:0] w;
      iCoreCfgReady = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         w = 32'hA5A5_0000 + 32'(k);
         iNpuConfigWe   = 1'b1;
         iNpuConfigFifo = w;
         tick();
         checks++;
         if (oCoreCfgValid !== 1'b1 || oCoreCfgData !== w) begin
            errors++;
            $display("FAIL cfg_head_%0d: got valid=%b data=%h required 1 %h",
                     k, oCoreCfgValid, oCoreCfgData, w);
         end
      end
      iNpuConfigWe = 1'b0;
      tick();
      checks++;
      if (oCoreCfgValid !== 1'b0) begin
         errors++;
         $display("FAIL cfg_valid_drop: got %b required 0", oCoreCfgValid);
      end
      iCoreCfgReady = 1'b0;
   endtask

   task automatic fillIn(input int n);
      iCoreInReady = 1'b0;
      for (int i = 0; i < n; i++) begin
         iNpuDataWe   = 1'b1;
         iNpuDataFifo = 32'(i);
         tick();
      end
      iNpuDataWe = 1'b0;
   endtask

   task automatic test_fill_overflow();
      fillIn(IN_DEPTH - 1);
      checks++;
      if (oInFull !== 1'b0) begin
         errors++;
         $display("FAIL in_full_early: got %b required 0", oInFull);
      end
      iNpuDataWe   = 1'b1;
      iNpuDataFifo = 32'(IN_DEPTH - 1);
      tick();
      checks++;
      if (oInFull !== 1'b1 || oOverflow !== 1'b0) begin
         errors++;
         $display("FAIL in_full: got full=%b ovf=%b required 1 0", oInFull, oOverflow);
      end
      iNpuDataFifo = 32'hDEAD;
      tick();
      iNpuDataWe = 1'b0;
      checks++;
      if (oOverflow !== 1'b1 || oInFull !== 1'b1) begin
         errors++;
         $display("FAIL in_overflow: got ovf=%b full=%b required 1 1", oOverflow, oInFull);
      end
      iCoreInReady = 1'b1;
      for (int i = 0; i < int'(IN_DEPTH); i++) begin
         checks++;
         if (oCoreInValid !== 1'b1 || oCoreInData !== 32'(i)) begin
            errors++;
            $display("FAIL in_drain_%0d: got valid=%b data=%h required 1 %h",
                     i, oCoreInValid, oCoreInData, 32'(i));
         end
         tick();
      end
      checks++;
      if (oCoreInValid !== 1'b0) begin
         errors++;
         $display("FAIL in_drain_end: got valid=%b required 0", oCoreInValid);
      end
      iCoreInReady = 1'b0;
      flush();
      checks++;
      if (oOverflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_flush: got %b required 0", oOverflow);
      end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp;
      fillIn(IN_DEPTH);
      iNpuDataWe   = 1'b1;
      iNpuDataFifo = 32'h77;
      iCoreInReady = 1'b1;
      tick();
      iNpuDataWe   = 1'b0;
      iCoreInReady = 1'b0;
      checks++;
      if (oInFull !== 1'b1 || oOverflow !== 1'b0 || oCoreInData !== 32'h1) begin
         errors++;
         $display("FAIL full_pushpop: got full=%b ovf=%b head=%h required 1 0 1",
                  oInFull, oOverflow, oCoreInData);
      end
      iCoreInReady = 1'b1;
      for (int i = 0; i < int'(IN_DEPTH); i++) begin
         exp = (i == int'(IN_DEPTH) - 1) ? 32'h77 : 32'(i + 1);
         checks++;
         if (oCoreInValid !== 1'b1 || oCoreInData !== exp) begin
            errors++;
            $display("FAIL pushpop_drain_%0d: got valid=%b data=%h required 1 %h",
                     i, oCoreInValid, oCoreInData, exp);
         end
         tick();
      end
      iCoreInReady = 1'b0;
   endtask

   task automatic test_back_to_back();
      iCoreOutValid = 1'b1;
      iCoreOutData  = 32'h10;
      tick();
      checks++;
      if (oOutEmpty !== 1'b0) begin
         errors++;
         $display("FAIL out_empty_fall: got %b required 0", oOutEmpty);
      end
      iCoreOutData = 32'h20;
      tick();
      iCoreOutValid = 1'b0;
      iNpuDataRe    = 1'b1;
      tick();
      checks++;
      if (oNpuDataFifo !== 32'h10) begin
         errors++;
         $display("FAIL deq_first: got %h required 10", oNpuDataFifo);
      end
      tick();
      iNpuDataRe = 1'b0;
      checks++;
      if (oNpuDataFifo !== 32'h20 || oOutEmpty !== 1'b1) begin
         errors++;
         $display("FAIL deq_second: got data=%h empty=%b required 20 1", oNpuDataFifo, oOutEmpty);
      end
      tick();
      checks++;
      if (oNpuDataFifo !== 32'h20) begin
         errors++;
         $display("FAIL deq_hold: got %h required 20", oNpuDataFifo);
      end
   endtask

   task automatic test_underflow();
      iNpuDataRe = 1'b1;
      tick();
      iNpuDataRe = 1'b0;
      checks++;
      if (oNpuDataFifo !== 32'h0 || oUnderflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow: got data=%h unf=%b required 0 1", oNpuDataFifo, oUnderflow);
      end
      flush();
      checks++;
      if (oUnderflow !== 1'b0) begin
         errors++;
         $display("FAIL unf_flush: got %b required 0", oUnderflow);
      end
   endtask

   task automatic test_reset_mid();
      iCoreCfgReady = 1'b0;
      iCoreInReady  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         iNpuConfigWe   = 1'b1;
         iNpuConfigFifo = 32'(200 + i);
         iNpuDataWe     = 1'b1;
         iNpuDataFifo   = 32'(300 + i);
         iCoreOutValid  = 1'b1;
         iCoreOutData   = 32'(100 + i);
         tick();
      end
      iNpuConfigWe = 1'b0;
      iNpuDataWe   = 1'b0;
      iCoreOutData = 32'(105);
      iNpuDataRe   = 1'b1;
      tick();
      iCoreOutValid = 1'b0;
      iNpuDataRe    = 1'b0;
      checks++;
      if (oNpuDataFifo !== 32'd100 || oCoreCfgValid !== 1'b1) begin
         errors++;
         $display("FAIL premid_state: got data=%h cfgv=%b required 64 1",
                  oNpuDataFifo, oCoreCfgValid);
      end
      #2;
      iRst_n = 1'b0;
      #1;
      modelClear();
      mData = 32'h0;
      checks++;
      if ({oCoreCfgValid, oCoreInValid, oOutEmpty, oCoreOutReady} !== 4'b0011) begin
         errors++;
         $display("FAIL async_reset_flags: got %b required 0011",
                  {oCoreCfgValid, oCoreInValid, oOutEmpty, oCoreOutReady});
      end
      checks++;
      if (oNpuDataFifo !== 32'h0) begin
         errors++;
         $display("FAIL async_reset_data: got %h required 0", oNpuDataFifo);
      end
      @(posedge iClk);
      #1;
      iRst_n = 1'b1;
   endtask

   task automatic test_random();
      int pWe, pRdy, pRe, pCore;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            pWe   = $urandom_range(10, 95);
            pRdy  = $urandom_range(5, 95);
            pRe   = $urandom_range(5, 95);
            pCore = $urandom_range(10, 95);
         end
         iNpuConfigWe   = ($urandom_range(0, 99) < pWe);
         iNpuConfigFifo = $urandom;
         iNpuDataWe     = ($urandom_range(0, 99) < pWe);
         iNpuDataFifo   = $urandom;
         iCoreCfgReady  = ($urandom_range(0, 99) < pRdy);
         iCoreInReady   = ($urandom_range(0, 99) < pRdy);
         iCoreOutValid  = ($urandom_range(0, 99) < pCore);
         iCoreOutData   = $urandom;
         iNpuDataRe     = ($urandom_range(0, 99) < pRe);
         iNpuFlush      = ($urandom_range(0, 199) == 0);
         tick();
         checks++;
         if (oCoreCfgValid !== (mCfg.size() != 0) || oCfgFull !== (mCfg.size() == CFG_DEPTH)) begin
            errors++;
            $display("FAIL rnd_cfg_flags c=%0d: got v=%b f=%b required count %0d",
                     c, oCoreCfgValid, oCfgFull, mCfg.size());
         end
         if (mCfg.size() != 0) begin
            checks++;
            if (oCoreCfgData !== mCfg[0]) begin
               errors++;
               $display("FAIL rnd_cfg_head c=%0d: got %h required %h", c, oCoreCfgData, mCfg[0]);
            end
         end
         checks++;
         if (oCoreInValid !== (mIn.size() != 0) || oInFull !== (mIn.size() == IN_DEPTH)) begin
            errors++;
            $display("FAIL rnd_in_flags c=%0d: got v=%b f=%b required count %0d",
                     c, oCoreInValid, oInFull, mIn.size());
         end
         if (mIn.size() != 0) begin
            checks++;
            if (oCoreInData !== mIn[0]) begin
               errors++;
               $display("FAIL rnd_in_head c=%0d: got %h required %h", c, oCoreInData, mIn[0]);
            end
         end
         checks++;
         if (oOutEmpty !== (mOut.size() == 0) || oCoreOutReady !== (mOut.size() < OUT_DEPTH)) begin
            errors++;
            $display("FAIL rnd_out_flags c=%0d: got e=%b r=%b required count %0d",
                     c, oOutEmpty, oCoreOutReady, mOut.size());
         end
         checks++;
         if (oOverflow !== mOvf || oUnderflow !== mUnf) begin
            errors++;
            $display("FAIL rnd_err_flags c=%0d: got ovf=%b unf=%b required %b %b",
                     c, oOverflow, oUnderflow, mOvf, mUnf);
         end
         checks++;
         if (oNpuDataFifo !== mData) begin
            errors++;
            $display("FAIL rnd_deq_data c=%0d: got %h required %h", c, oNpuDataFifo, mData);
         end
      end
      idleInputs();
   endtask

   initial begin
      idleInputs();
      iRst_n = 1'b0;
      test_reset();
      test_cfg_stream();
      test_fill_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_underflow();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
